// File: rtl/bp_pkg.sv
// Shared types and constants for the branch target predictor: BTB entry layout,
// 2-bit saturating counter encoding and its transition function.
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_ctr_e;

  localparam int BP_DATA_W   = 32;
  localparam int BTB_ENTRIES = 16;
  localparam int BP_IDX_W    = $clog2(BTB_ENTRIES);
  localparam int BP_TAG_W    = BP_DATA_W - BP_IDX_W - 2;

  localparam logic [BP_DATA_W-1:0] PC_INCR = 32'd4;

  typedef struct packed {
    logic                 valid;
    logic [BP_TAG_W-1:0]  tag;
    logic [BP_DATA_W-1:0] target;
    bp_ctr_e              ctr;
    logic                 is_jump;
  } btb_entry_t;

  // Cleared entry; the counter starts weakly not-taken.
  localparam btb_entry_t BTB_ENTRY_RESET = '{
    valid:   1'b0,
    tag:     {BP_TAG_W{1'b0}},
    target:  {BP_DATA_W{1'b0}},
    ctr:     WNT,
    is_jump: 1'b0
  };

  function automatic bp_ctr_e ctr_next(input bp_ctr_e ctr, input logic taken);
    case (ctr)
      SNT:     ctr_next = taken ? WNT : SNT;
      WNT:     ctr_next = taken ? WT  : SNT;
      WT:      ctr_next = taken ? ST  : WNT;
      ST:      ctr_next = taken ? ST  : WT;
      default: ctr_next = WNT;
    endcase
  endfunction

endpackage

// File: rtl/bp_table.sv
// Direct-mapped BTB storage: async-reset clear, two combinational read ports
// (fetch lookup and EX-resolution lookup) and one synchronous write port.
module bp_table
  import bp_pkg::*;
#(
  parameter int ENTRIES = BTB_ENTRIES,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] i_rd_idx_a,
  output btb_entry_t       o_rd_entry_a,
  input  logic [IDX_W-1:0] i_rd_idx_b,
  output btb_entry_t       o_rd_entry_b,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  btb_entry_t       i_wr_entry
);

  btb_entry_t r_mem [ENTRIES];

  assign o_rd_entry_a = r_mem[i_rd_idx_a];
  assign o_rd_entry_b = r_mem[i_rd_idx_b];

  // Entry storage; reset clears every entry immediately, discarding any pending write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_mem[i] <= BTB_ENTRY_RESET;
      end
    end else if (i_wr_en) begin
      r_mem[i_wr_idx] <= i_wr_entry;
    end
  end

endmodule

// File: rtl/branch_target_predictor.sv
// Next-PC generator: BTB lookup on the fetch address, mispredict override from EX,
// table training on resolution and branch/mispredict performance counters.
module branch_target_predictor
  import bp_pkg::*;
#(
  parameter int DATA_W  = BP_DATA_W,
  parameter int ENTRIES = BTB_ENTRIES,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int TAG_W   = DATA_W - IDX_W - 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pc_cur,
  input  logic              stall,
  input  logic              ex_valid,
  input  logic              ex_is_jump,
  input  logic [DATA_W-1:0] ex_pc,
  input  logic              ex_taken,
  input  logic [DATA_W-1:0] ex_target,
  input  logic              ex_pred_taken,
  input  logic [DATA_W-1:0] ex_pred_target,
  output logic [DATA_W-1:0] PC_in_pred,
  output logic              pred_taken,
  output logic [DATA_W-1:0] pred_target,
  output logic              flush,
  output logic [31:0]       branch_cnt,
  output logic [31:0]       mispred_cnt
);

  logic [IDX_W-1:0] w_lk_idx;
  logic [IDX_W-1:0] w_ex_idx;
  logic [TAG_W-1:0] w_lk_tag;
  logic [TAG_W-1:0] w_ex_tag;
  btb_entry_t       w_lk_entry;
  btb_entry_t       w_ex_entry;
  btb_entry_t       w_wr_entry;
  logic             w_wr_en;
  logic             w_lk_hit;
  logic             w_ex_hit;
  logic             w_mispredict;
  logic             w_update;
  logic [31:0]      r_branch_cnt;
  logic [31:0]      r_mispred_cnt;

  assign w_lk_idx = pc_cur[IDX_W+1:2];
  assign w_lk_tag = pc_cur[DATA_W-1:IDX_W+2];
  assign w_ex_idx = ex_pc[IDX_W+1:2];
  assign w_ex_tag = ex_pc[DATA_W-1:IDX_W+2];

  bp_table #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W)
  ) u_table (
    .clk          (clk),
    .rst          (rst),
    .i_rd_idx_a   (w_lk_idx),
    .o_rd_entry_a (w_lk_entry),
    .i_rd_idx_b   (w_ex_idx),
    .o_rd_entry_b (w_ex_entry),
    .i_wr_en      (w_wr_en),
    .i_wr_idx     (w_ex_idx),
    .i_wr_entry   (w_wr_entry)
  );

  assign w_lk_hit    = w_lk_entry.valid && (w_lk_entry.tag == w_lk_tag);
  assign w_ex_hit    = w_ex_entry.valid && (w_ex_entry.tag == w_ex_tag);
  assign pred_taken  = w_lk_hit && (w_lk_entry.is_jump || w_lk_entry.ctr[1]);
  assign pred_target = pred_taken ? w_lk_entry.target : (pc_cur + PC_INCR);

  // A wrong target on a correctly-predicted-taken branch is still a redirect.
  assign w_mispredict = ex_valid && ((ex_taken != ex_pred_taken) ||
                                     (ex_taken && (ex_target != ex_pred_target)));
  assign flush    = w_mispredict;
  assign w_update = ex_valid && !stall;

  // Next-PC select: EX correction overrides the fetch-stage prediction.
  always_comb begin
    PC_in_pred = pred_target;
    if (w_mispredict) begin
      PC_in_pred = ex_taken ? ex_target : (ex_pc + PC_INCR);
    end else begin
      PC_in_pred = pred_target;
    end
  end

  // Training: hits adjust the counter, taken misses allocate, not-taken misses leave the table alone.
  always_comb begin
    w_wr_en    = 1'b0;
    w_wr_entry = w_ex_entry;
    if (w_update && w_ex_hit) begin
      w_wr_en            = 1'b1;
      w_wr_entry.ctr     = ctr_next(w_ex_entry.ctr, ex_taken);
      w_wr_entry.is_jump = ex_is_jump;
      if (ex_taken) begin
        w_wr_entry.target = ex_target;
      end else begin
        w_wr_entry.target = w_ex_entry.target;
      end
    end else if (w_update && ex_taken) begin
      w_wr_en    = 1'b1;
      w_wr_entry = '{valid: 1'b1, tag: w_ex_tag, target: ex_target, ctr: WT, is_jump: ex_is_jump};
    end else begin
      w_wr_en    = 1'b0;
      w_wr_entry = w_ex_entry;
    end
  end

  // Performance counters, wrapping naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_branch_cnt  <= 32'd0;
      r_mispred_cnt <= 32'd0;
    end else if (w_update) begin
      r_branch_cnt  <= r_branch_cnt + 32'd1;
      r_mispred_cnt <= r_mispred_cnt + (w_mispredict ? 32'd1 : 32'd0);
    end
  end

  assign branch_cnt  = r_branch_cnt;
  assign mispred_cnt = r_mispred_cnt;

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench for branch_target_predictor: reset, allocation, counter walk,
// stall, aliasing, target mismatch, jumps, address wrap and async reset.
module tb_branch_target_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] pc_cur;
  logic        stall;
  logic        ex_valid;
  logic        ex_is_jump;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic [31:0] PC_in_pred;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        flush;
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;

  int checks = 0;
  int errors = 0;

  branch_target_predictor dut (
    .clk            (clk),
    .rst            (rst),
    .pc_cur         (pc_cur),
    .stall          (stall),
    .ex_valid       (ex_valid),
    .ex_is_jump     (ex_is_jump),
    .ex_pc          (ex_pc),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .PC_in_pred     (PC_in_pred),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .flush          (flush),
    .branch_cnt     (branch_cnt),
    .mispred_cnt    (mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_ex(input logic v, input logic j, input logic [31:0] pc,
                          input logic t, input logic [31:0] tgt,
                          input logic pt, input logic [31:0] ptgt);
    ex_valid       = v;
    ex_is_jump     = j;
    ex_pc          = pc;
    ex_taken       = t;
    ex_target      = tgt;
    ex_pred_taken  = pt;
    ex_pred_target = ptgt;
  endtask

  task automatic idle_ex();
    drive_ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    rst    = 1'b0;
    stall  = 1'b0;
    pc_cur = 32'h0FFF_FFFC;
    idle_ex();

    // Reset
    #2 rst = 1'b1;
    #1;
    check("rst_pc_in_pred", PC_in_pred, 32'h1000_0000);
    check("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
    check("rst_flush", {31'd0, flush}, 32'd0);
    check("rst_branch_cnt", branch_cnt, 32'd0);
    check("rst_mispred_cnt", mispred_cnt, 32'd0);

    // Taken branch predicted not-taken: allocate with WT
    @(negedge clk);
    rst    = 1'b0;
    pc_cur = 32'h1000_0020;
    drive_ex(1'b1, 1'b0, 32'h1000_0010, 1'b1, 32'h1000_0040, 1'b0, 32'h1000_0014);
    #1;
    check("alloc_flush", {31'd0, flush}, 32'd1);
    check("alloc_redirect", PC_in_pred, 32'h1000_0040);
    @(negedge clk);
    idle_ex();
    pc_cur = 32'h1000_0010;
    #1;
    check("alloc_pred_taken", {31'd0, pred_taken}, 32'd1);
    check("alloc_pc_in_pred", PC_in_pred, 32'h1000_0040);
    check("alloc_pred_target", pred_target, 32'h1000_0040);
    check("alloc_flush_clear", {31'd0, flush}, 32'd0);
    check("alloc_mispred_cnt", mispred_cnt, 32'd1);
    check("alloc_branch_cnt", branch_cnt, 32'd1);

    // Not-taken #1 (mispredicted): WT -> WNT; same-cycle lookup sees old entry
    @(negedge clk);
    drive_ex(1'b1, 1'b0, 32'h1000_0010, 1'b0, 32'h1000_0040, 1'b1, 32'h1000_0040);
    #1;
    check("nt1_flush", {31'd0, flush}, 32'd1);
    check("nt1_redirect_fallthru", PC_in_pred, 32'h1000_0014);
    check("nt1_no_bypass", {31'd0, pred_taken}, 32'd1);
    @(negedge clk);
    idle_ex();
    #1;
    check("nt1_pred_taken", {31'd0, pred_taken}, 32'd0);
    check("nt1_pc_in_pred", PC_in_pred, 32'h1000_0014);

    // Not-taken #2 (correct): WNT -> SNT
    drive_ex(1'b1, 1'b0, 32'h1000_0010, 1'b0, 32'h1000_0040, 1'b0, 32'h1000_0014);
    #1;
    check("nt2_flush", {31'd0, flush}, 32'd0);
    check("nt2_pc_in_pred", PC_in_pred, 32'h1000_0014);
    // Not-taken #3: SNT saturates
    @(negedge clk);
    #1;
    check("nt3_pred_taken_before", {31'd0, pred_taken}, 32'd0);
    @(negedge clk);
    idle_ex();
    #1;
    check("sat_low_pred_taken", {31'd0, pred_taken}, 32'd0);
    check("sat_low_branch_cnt", branch_cnt, 32'd4);
    check("sat_low_mispred_cnt", mispred_cnt, 32'd2);

    // Taken twice from SNT: first reaches WNT (still not-taken), second reaches WT
    drive_ex(1'b1, 1'b0, 32'h1000_0010, 1'b1, 32'h1000_0040, 1'b0, 32'h1000_0014);
    @(negedge clk);
    idle_ex();
    #1;
    check("up1_pred_taken", {31'd0, pred_taken}, 32'd0);
    @(negedge clk);
    drive_ex(1'b1, 1'b0, 32'h1000_0010, 1'b1, 32'h1000_0040, 1'b0, 32'h1000_0014);
    @(negedge clk);
    idle_ex();
    #1;
    check("up2_pred_taken", {31'd0, pred_taken}, 32'd1);
    check("up2_branch_cnt", branch_cnt, 32'd6);
    check("up2_mispred_cnt", mispred_cnt, 32'd4);

    // Stalled mispredict: flush still raised, nothing updated
    @(negedge clk);
    stall = 1'b1;
    drive_ex(1'b1, 1'b0, 32'h1000_0010, 1'b0, 32'h1000_0040, 1'b1, 32'h1000_0040);
    #1;
    check("stall_flush", {31'd0, flush}, 32'd1);
    check("stall_redirect", PC_in_pred, 32'h1000_0014);
    @(negedge clk);
    stall = 1'b0;
    idle_ex();
    #1;
    check("stall_table_kept", {31'd0, pred_taken}, 32'd1);
    check("stall_branch_cnt", branch_cnt, 32'd6);
    check("stall_mispred_cnt", mispred_cnt, 32'd4);

    // Aliasing: 0x1000_0050 shares the index, replaces the entry
    drive_ex(1'b1, 1'b0, 32'h1000_0050, 1'b1, 32'h1000_0080, 1'b0, 32'h1000_0054);
    @(negedge clk);
    idle_ex();
    #1;
    check("alias_old_miss", {31'd0, pred_taken}, 32'd0);
    check("alias_old_pc_in_pred", PC_in_pred, 32'h1000_0014);
    pc_cur = 32'h1000_0050;
    #1;
    check("alias_new_hit", {31'd0, pred_taken}, 32'd1);
    check("alias_new_pc_in_pred", PC_in_pred, 32'h1000_0080);

    // Taken with wrong predicted target: redirect and retarget
    @(negedge clk);
    drive_ex(1'b1, 1'b0, 32'h1000_0050, 1'b1, 32'h1000_0090, 1'b1, 32'h1000_0080);
    #1;
    check("tgt_flush", {31'd0, flush}, 32'd1);
    check("tgt_redirect", PC_in_pred, 32'h1000_0090);
    @(negedge clk);
    idle_ex();
    #1;
    check("tgt_retrained", PC_in_pred, 32'h1000_0090);

    // Jump: allocated, then trained not-taken but still predicted taken via is_jump
    drive_ex(1'b1, 1'b1, 32'h1000_0100, 1'b1, 32'h1000_0200, 1'b0, 32'h1000_0104);
    @(negedge clk);
    pc_cur = 32'h1000_0100;
    drive_ex(1'b1, 1'b1, 32'h1000_0100, 1'b0, 32'h1000_0200, 1'b1, 32'h1000_0200);
    #1;
    check("jmp_hit_pred", PC_in_pred, 32'h1000_0104);
    check("jmp_lookup_pred_target", pred_target, 32'h1000_0200);
    @(negedge clk);
    idle_ex();
    #1;
    check("jmp_still_taken", {31'd0, pred_taken}, 32'd1);

    // Correctly predicted branch: no flush, counters only count the branch
    pc_cur = 32'h1000_0050;
    drive_ex(1'b1, 1'b0, 32'h1000_0050, 1'b1, 32'h1000_0090, 1'b1, 32'h1000_0090);
    #1;
    check("ok_flush", {31'd0, flush}, 32'd0);
    check("ok_pc_in_pred", PC_in_pred, 32'h1000_0090);
    @(negedge clk);
    idle_ex();
    #1;
    check("ok_branch_cnt", branch_cnt, 32'd11);
    check("ok_mispred_cnt", mispred_cnt, 32'd8);

    // Address wrap on an unused entry
    pc_cur = 32'hFFFF_FFFC;
    #1;
    check("wrap_pc_in_pred", PC_in_pred, 32'h0000_0000);

    // Async reset mid-cycle while an update is pending
    @(negedge clk);
    pc_cur = 32'h1000_0050;
    drive_ex(1'b1, 1'b0, 32'h1000_0300, 1'b1, 32'h1000_0400, 1'b0, 32'h1000_0304);
    #2 rst = 1'b1;
    #1;
    check("arst_pred_taken", {31'd0, pred_taken}, 32'd0);
    check("arst_pc_in_pred", pred_target, 32'h1000_0054);
    check("arst_branch_cnt", branch_cnt, 32'd0);
    check("arst_mispred_cnt", mispred_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_ex();
    pc_cur = 32'h1000_0300;
    #1;
    check("arst_update_dropped", {31'd0, pred_taken}, 32'd0);
    check("arst_pc_after", PC_in_pred, 32'h1000_0304);
    check("arst_cnt_after", branch_cnt, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
